// File: rtl/serial_pattern_gen.sv
// Serial pattern transmitter: sends a latched pattern MSB-first with optional filler gaps.
// Optional PRBS gap filler is enabled by defining SERIAL_PATTERN_GEN_PRBS_FILL_EN.
module serial_pattern_gen #(
  parameter int PAT_W = 4,
  parameter int REP_W = 8,
  parameter int GAP_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [PAT_W-1:0] req_pattern,
  input  logic [REP_W-1:0] req_reps,
  input  logic [GAP_W-1:0] req_gap,
  input  logic             abort,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pat_count
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

  state_t           r_state;
  logic [PAT_W-1:0] r_pattern;
  logic [REP_W-1:0] r_repsLeft;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gapCnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_serOut;
  logic             r_serValid;
  logic             r_busy;
  logic             r_done;
  logic             r_reqReady;
  logic [CNT_W-1:0] r_patCount;

  state_t           w_nextState;
  logic [PAT_W-1:0] w_pattern;
  logic [REP_W-1:0] w_repsLeft;
  logic [GAP_W-1:0] w_gap;
  logic [GAP_W-1:0] w_gapCnt;
  logic [IDX_W-1:0] w_idx;
  logic             w_serOut;
  logic             w_serValid;
  logic             w_busy;
  logic             w_done;
  logic             w_countInc;
  logic             w_fillBit;

`ifdef SERIAL_PATTERN_GEN_PRBS_FILL_EN
  logic [6:0] r_lfsr;

  // x^7+x^6+1 filler source; survives aborts and new requests, only reset reseeds it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr <= 7'h7F;
    end else if (r_state == GAP && !abort) begin
      r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
    end
  end

  assign w_fillBit = r_lfsr[6];
`else
  assign w_fillBit = 1'b0;
`endif

  always_comb begin
    w_nextState = r_state;
    w_pattern   = r_pattern;
    w_repsLeft  = r_repsLeft;
    w_gap       = r_gap;
    w_gapCnt    = r_gapCnt;
    w_idx       = r_idx;
    w_serOut    = 1'b0;
    w_serValid  = 1'b0;
    w_done      = 1'b0;
    w_countInc  = 1'b0;
    w_busy      = 1'b0;

    case (r_state)
      IDLE: begin
        // r_reqReady gates acceptance so a request is never taken while req_ready reads 0
        if (req_valid && r_reqReady) begin
          w_pattern  = req_pattern;
          w_repsLeft = req_reps;
          w_gap      = req_gap;
          w_idx      = LAST_IDX;
          w_nextState = (req_reps == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        if (abort) begin
          w_nextState = IDLE;
        end else begin
          w_serValid = 1'b1;
          w_serOut   = r_pattern[r_idx];
          if (r_idx == '0) begin
            w_countInc = 1'b1;
            w_repsLeft = r_repsLeft - REP_W'(1);
            if (r_repsLeft == REP_W'(1)) begin
              w_nextState = DONE;
            end else if (r_gap != '0) begin
              w_nextState = GAP;
              w_gapCnt    = r_gap;
            end else begin
              w_idx = LAST_IDX;
            end
          end else begin
            w_idx = r_idx - IDX_W'(1);
          end
        end
      end
      GAP: begin
        if (abort) begin
          w_nextState = IDLE;
        end else begin
          w_serValid = 1'b1;
          w_serOut   = w_fillBit;
          if (r_gapCnt == GAP_W'(1)) begin
            w_nextState = SHIFT;
            w_idx       = LAST_IDX;
          end else begin
            w_gapCnt = r_gapCnt - GAP_W'(1);
          end
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase

    // busy covers the cycle in which done is shown, and drops at once on abort
    w_busy = (w_nextState != IDLE) || (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_pattern  <= '0;
      r_repsLeft <= '0;
      r_gap      <= '0;
      r_gapCnt   <= '0;
      r_idx      <= '0;
      r_serOut   <= 1'b0;
      r_serValid <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_reqReady <= 1'b1;
      r_patCount <= '0;
    end else begin
      r_state    <= w_nextState;
      r_pattern  <= w_pattern;
      r_repsLeft <= w_repsLeft;
      r_gap      <= w_gap;
      r_gapCnt   <= w_gapCnt;
      r_idx      <= w_idx;
      r_serOut   <= w_serOut;
      r_serValid <= w_serValid;
      r_busy     <= w_busy;
      r_done     <= w_done;
      r_reqReady <= ~w_busy;
      if (w_countInc) begin
        r_patCount <= r_patCount + CNT_W'(1);
      end
    end
  end

  assign ser_out   = r_serOut;
  assign ser_valid = r_serValid;
  assign busy      = r_busy;
  assign done      = r_done;
  assign req_ready = r_reqReady;
  assign pat_count = r_patCount;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Self-checking bench for serial_pattern_gen: directed and random requests against a
// queue-based model of the expected serial stream (PRBS filler modelled when enabled).
module tb_serial_pattern_gen;

  localparam int PAT_W = 4;
  localparam int REP_W = 8;
  localparam int GAP_W = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [PAT_W-1:0] req_pattern = '0;
  logic [REP_W-1:0] req_reps = '0;
  logic [GAP_W-1:0] req_gap = '0;
  logic             abort = 1'b0;
  logic             ser_out;
  logic             ser_valid;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pat_count;

  int   testsRun = 0;
  int   testsFailed = 0;
  bit   expBits[$];
  int   modelCount = 0;
  logic [6:0] modelLfsr = 7'h7F;

  serial_pattern_gen #(.PAT_W(PAT_W), .REP_W(REP_W), .GAP_W(GAP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_pattern(req_pattern), .req_reps(req_reps), .req_gap(req_gap), .abort(abort),
    .ser_out(ser_out), .ser_valid(ser_valid), .busy(busy), .done(done), .pat_count(pat_count)
  );

  always #5 clk = ~clk;

  function automatic bit nextFill();
`ifdef SERIAL_PATTERN_GEN_PRBS_FILL_EN
    bit b;
    b = modelLfsr[6];
    modelLfsr = {modelLfsr[5:0], modelLfsr[6] ^ modelLfsr[5]};
    return b;
`else
    return 1'b0;
`endif
  endfunction

  // Expected stream: reps copies of the pattern MSB-first, gap filler only between copies
  task automatic buildExpected(input logic [PAT_W-1:0] pat, input int reps, input int gap);
    expBits.delete();
    for (int r = 0; r < reps; r++) begin
      for (int b = PAT_W - 1; b >= 0; b--) expBits.push_back(pat[b]);
      if (r < reps - 1)
        for (int g = 0; g < gap; g++) expBits.push_back(nextFill());
    end
  endtask

  task automatic applyStimulus(input logic [PAT_W-1:0] pat, input int reps, input int gap,
                               input bit keepValid, output int edges);
    bit rdy;
    req_pattern = pat;
    req_reps    = REP_W'(reps);
    req_gap     = GAP_W'(gap);
    req_valid   = 1'b1;
    edges       = -1;
    for (int i = 1; i <= 40; i++) begin
      rdy = req_ready;
      @(posedge clk); #1;
      if (rdy) begin
        edges = i;
        break;
      end
    end
    if (!keepValid) req_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #8;
    testsRun++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || ser_valid !== 1'b0 ||
        ser_out !== 1'b0 || pat_count !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_hold: ready=%b busy=%b done=%b valid=%b out=%b cnt=%0d, required 1 0 0 0 0 0",
               req_ready, busy, done, ser_valid, ser_out, pat_count);
    end
    #2 rst = 1'b1;
    modelCount = 0;
    modelLfsr  = 7'h7F;
    @(posedge clk); #1;
    testsRun++;
    if (req_ready !== 1'b1 || busy !== 1'b0 || ser_valid !== 1'b0 || pat_count !== '0) begin
      testsFailed++;
      $display("[TB] FAIL reset_release: ready=%b busy=%b valid=%b cnt=%0d, required 1 0 0 0",
               req_ready, busy, ser_valid, pat_count);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    buildExpected(4'b1010, 3, 0);
    applyStimulus(4'b1010, 3, 0, 1'b0, edges);
    testsRun++;
    if (edges !== 1 || busy !== 1'b1 || req_ready !== 1'b0 || ser_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_accept: edges=%0d busy=%b ready=%b valid=%b, required 1 1 0 0",
               edges, busy, req_ready, ser_valid);
    end
    for (int n = 0; n < expBits.size(); n++) begin
      @(posedge clk); #1;
      testsRun++;
      if (ser_valid !== 1'b1 || ser_out !== expBits[n]) begin
        testsFailed++;
        $display("[TB] FAIL b2b_bit%0d: valid=%b out=%b, required 1 %b", n, ser_valid, ser_out, expBits[n]);
      end
    end
    modelCount += 3;
    @(posedge clk); #1;
    testsRun++;
    if (done !== 1'b1 || ser_valid !== 1'b0 || ser_out !== 1'b0 || busy !== 1'b1 ||
        pat_count !== CNT_W'(modelCount)) begin
      testsFailed++;
      $display("[TB] FAIL b2b_done: done=%b valid=%b out=%b busy=%b cnt=%0d, required 1 0 0 1 %0d",
               done, ser_valid, ser_out, busy, pat_count, modelCount);
    end
    @(posedge clk); #1;
    testsRun++;
    if (done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL b2b_idle: done=%b ready=%b busy=%b, required 0 1 0", done, req_ready, busy);
    end
  endtask

  task automatic test_gap();
    int edges;
    buildExpected(4'b1010, 2, 2);
    applyStimulus(4'b1010, 2, 2, 1'b0, edges);
    testsRun++;
    if (edges !== 1) begin
      testsFailed++;
      $display("[TB] FAIL gap_accept: edges=%0d, required 1", edges);
    end
    for (int n = 0; n < expBits.size(); n++) begin
      @(posedge clk); #1;
      testsRun++;
      if (ser_valid !== 1'b1 || ser_out !== expBits[n]) begin
        testsFailed++;
        $display("[TB] FAIL gap_bit%0d: valid=%b out=%b, required 1 %b", n, ser_valid, ser_out, expBits[n]);
      end
    end
    modelCount += 2;
    @(posedge clk); #1;
    testsRun++;
    if (done !== 1'b1 || ser_valid !== 1'b0 || req_ready !== 1'b0 || pat_count !== CNT_W'(modelCount)) begin
      testsFailed++;
      $display("[TB] FAIL gap_done: done=%b valid=%b ready=%b cnt=%0d, required 1 0 0 %0d",
               done, ser_valid, req_ready, pat_count, modelCount);
    end
    @(posedge clk); #1;
    testsRun++;
    if (req_ready !== 1'b1 || done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL gap_ready: ready=%b done=%b, required 1 0", req_ready, done);
    end
  endtask

  task automatic test_zero_reps();
    int edges;
    applyStimulus(4'b1111, 0, 3, 1'b0, edges);
    testsRun++;
    if (edges !== 1 || busy !== 1'b1 || ser_valid !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL zero_accept: edges=%0d busy=%b valid=%b, required 1 1 0", edges, busy, ser_valid);
    end
    @(posedge clk); #1;
    testsRun++;
    if (done !== 1'b1 || ser_valid !== 1'b0 || pat_count !== CNT_W'(modelCount)) begin
      testsFailed++;
      $display("[TB] FAIL zero_done: done=%b valid=%b cnt=%0d, required 1 0 %0d",
               done, ser_valid, pat_count, modelCount);
    end
    @(posedge clk); #1;
    testsRun++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL zero_idle: done=%b ready=%b, required 0 1", done, req_ready);
    end
  endtask

  task automatic test_abort();
    int edges;
    buildExpected(4'b1100, 4, 0);
    applyStimulus(4'b1100, 4, 0, 1'b0, edges);
    for (int n = 0; n < 6; n++) begin
      @(posedge clk); #1;
      testsRun++;
      if (ser_valid !== 1'b1 || ser_out !== expBits[n]) begin
        testsFailed++;
        $display("[TB] FAIL abort_bit%0d: valid=%b out=%b, required 1 %b", n, ser_valid, ser_out, expBits[n]);
      end
    end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    modelCount += 1;
    testsRun++;
    if (ser_valid !== 1'b0 || ser_out !== 1'b0 || done !== 1'b0 || busy !== 1'b0 ||
        req_ready !== 1'b1 || pat_count !== CNT_W'(modelCount)) begin
      testsFailed++;
      $display("[TB] FAIL abort_stop: valid=%b out=%b done=%b busy=%b ready=%b cnt=%0d, required 0 0 0 0 1 %0d",
               ser_valid, ser_out, done, busy, req_ready, pat_count, modelCount);
    end
    buildExpected(4'b0110, 1, 0);
    applyStimulus(4'b0110, 1, 0, 1'b0, edges);
    testsRun++;
    if (edges !== 1 || done !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL abort_reaccept: edges=%0d done=%b, required 1 0", edges, done);
    end
    for (int n = 0; n < expBits.size(); n++) begin
      @(posedge clk); #1;
      testsRun++;
      if (ser_valid !== 1'b1 || ser_out !== expBits[n]) begin
        testsFailed++;
        $display("[TB] FAIL abort_next_bit%0d: valid=%b out=%b, required 1 %b", n, ser_valid, ser_out, expBits[n]);
      end
    end
    modelCount += 1;
    @(posedge clk); #1;
    testsRun++;
    if (done !== 1'b1 || pat_count !== CNT_W'(modelCount)) begin
      testsFailed++;
      $display("[TB] FAIL abort_next_done: done=%b cnt=%0d, required 1 %0d", done, pat_count, modelCount);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    int edges;
    buildExpected(4'b1010, 2, 3);
    applyStimulus(4'b1010, 2, 3, 1'b0, edges);
    repeat (5) begin
      @(posedge clk); #1;
    end
    testsRun++;
    if (ser_valid !== 1'b1 || busy !== 1'b1 || pat_count !== CNT_W'(modelCount + 1)) begin
      testsFailed++;
      $display("[TB] FAIL areset_ingap: valid=%b busy=%b cnt=%0d, required 1 1 %0d",
               ser_valid, busy, pat_count, modelCount + 1);
    end
    #3 rst = 1'b0;
    #1;
    testsRun++;
    if (ser_valid !== 1'b0 || ser_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        req_ready !== 1'b1 || pat_count !== '0) begin
      testsFailed++;
      $display("[TB] FAIL areset_now: valid=%b out=%b busy=%b done=%b ready=%b cnt=%0d, required 0 0 0 0 1 0",
               ser_valid, ser_out, busy, done, req_ready, pat_count);
    end
    #2 rst = 1'b1;
    modelCount = 0;
    modelLfsr  = 7'h7F;
    @(posedge clk); #1;
    testsRun++;
    if (done !== 1'b0 || ser_valid !== 1'b0 || pat_count !== '0) begin
      testsFailed++;
      $display("[TB] FAIL areset_after: done=%b valid=%b cnt=%0d, required 0 0 0", done, ser_valid, pat_count);
    end
  endtask

  task automatic test_held_valid();
    int edges;
    buildExpected(4'b1001, 2, 3);
    applyStimulus(4'b1001, 2, 3, 1'b1, edges);
    req_pattern = 4'b0111;
    req_reps    = REP_W'(1);
    req_gap     = GAP_W'(2);
    for (int n = 0; n < expBits.size(); n++) begin
      @(posedge clk); #1;
      testsRun++;
      if (ser_valid !== 1'b1 || ser_out !== expBits[n] || req_ready !== 1'b0) begin
        testsFailed++;
        $display("[TB] FAIL held_bit%0d: valid=%b out=%b ready=%b, required 1 %b 0",
                 n, ser_valid, ser_out, req_ready, expBits[n]);
      end
    end
    modelCount += 2;
    @(posedge clk); #1;
    testsRun++;
    if (done !== 1'b1 || req_ready !== 1'b0 || pat_count !== CNT_W'(modelCount)) begin
      testsFailed++;
      $display("[TB] FAIL held_done: done=%b ready=%b cnt=%0d, required 1 0 %0d",
               done, req_ready, pat_count, modelCount);
    end
    @(posedge clk); #1;
    testsRun++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL held_ready: ready=%b busy=%b, required 1 0", req_ready, busy);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    testsRun++;
    if (busy !== 1'b1 || req_ready !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL held_second_accept: busy=%b ready=%b, required 1 0", busy, req_ready);
    end
    buildExpected(4'b0111, 1, 2);
    for (int n = 0; n < expBits.size(); n++) begin
      @(posedge clk); #1;
      testsRun++;
      if (ser_valid !== 1'b1 || ser_out !== expBits[n]) begin
        testsFailed++;
        $display("[TB] FAIL held_second_bit%0d: valid=%b out=%b, required 1 %b", n, ser_valid, ser_out, expBits[n]);
      end
    end
    modelCount += 1;
    @(posedge clk); #1;
    testsRun++;
    if (done !== 1'b1 || pat_count !== CNT_W'(modelCount)) begin
      testsFailed++;
      $display("[TB] FAIL held_second_done: done=%b cnt=%0d, required 1 %0d", done, pat_count, modelCount);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int edges;
    logic [PAT_W-1:0] pat;
    int reps;
    int gap;
    for (int t = 0; t < 8; t++) begin
      pat  = PAT_W'($urandom);
      reps = int'($urandom_range(0, 4));
      gap  = int'($urandom_range(0, 3));
      buildExpected(pat, reps, gap);
      applyStimulus(pat, reps, gap, 1'b0, edges);
      testsRun++;
      if (edges !== 1) begin
        testsFailed++;
        $display("[TB] FAIL rand%0d_accept: edges=%0d, required 1", t, edges);
      end
      for (int n = 0; n < expBits.size(); n++) begin
        @(posedge clk); #1;
        testsRun++;
        if (ser_valid !== 1'b1 || ser_out !== expBits[n]) begin
          testsFailed++;
          $display("[TB] FAIL rand%0d_bit%0d: valid=%b out=%b, required 1 %b (pat=%b reps=%0d gap=%0d)",
                   t, n, ser_valid, ser_out, expBits[n], pat, reps, gap);
        end
      end
      modelCount += reps;
      @(posedge clk); #1;
      testsRun++;
      if (done !== 1'b1 || ser_valid !== 1'b0 || pat_count !== CNT_W'(modelCount)) begin
        testsFailed++;
        $display("[TB] FAIL rand%0d_done: done=%b valid=%b cnt=%0d, required 1 0 %0d",
                 t, done, ser_valid, pat_count, modelCount);
      end
      @(posedge clk); #1;
      testsRun++;
      if (done !== 1'b0 || req_ready !== 1'b1) begin
        testsFailed++;
        $display("[TB] FAIL rand%0d_idle: done=%b ready=%b, required 0 1", t, done, req_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gap();
    test_zero_reps();
    test_abort();
    test_async_reset();
    test_held_valid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Guards against a stalled run if the DUT never responds
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
